// File: rtl/riscv_branch_predictor.sv
// riscv_branch_predictor: direct-mapped BTB with per-entry saturating counters, fetch lookup and execute-stage resolve/update.
// Mispredict detection and branch statistics are handled here as well.
module riscv_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic [XLEN-1:0] PCE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    input  logic            StallE,
    output logic            MispredictE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic [31:0]     NumBranches,
    output logic [31:0]     NumMispredicts
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic                valid_q [ENTRIES];
    logic                jmp_q   [ENTRIES];
    logic [TW-1:0]       tag_q   [ENTRIES];
    logic [XLEN-1:0]     tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
    logic [31:0]         nb_q, nm_q;

    logic [IDX-1:0]      idx_f, idx_e;
    logic [TW-1:0]       tag_f, tag_e;
    logic                hit_f, hit_e, upd, inval;
    logic [CTR_BITS-1:0] ctr_d;

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[XLEN-1:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[XLEN-1:IDX+2];

    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && (jmp_q[idx_f] || ctr_q[idx_f][CTR_BITS-1]);
    assign PredTargetF = PredTakenF ? tgt_q[idx_f] : PCF + XLEN'(4);

    assign MispredictE = !StallE && ((TakenE != PredTakenE)
                       || (TakenE && PredTakenE && (PredTargetE != PCTargetE))
                       || (PredTakenE && !BranchE && !JumpE));
    assign RedirectPCE = TakenE ? PCTargetE : PCE + XLEN'(4);

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign upd   = !StallE && (BranchE || JumpE);
    // a predicted-taken non-control instruction means the entry is stale
    assign inval = !StallE && !BranchE && !JumpE && PredTakenE && hit_e;

    always_comb begin
        ctr_d = ctr_q[idx_e];
        if (TakenE && ctr_q[idx_e] != CTR_MAX) ctr_d = ctr_q[idx_e] + CTR_BITS'(1);
        else if (!TakenE && ctr_q[idx_e] != '0) ctr_d = ctr_q[idx_e] - CTR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jmp_q[i]   <= 1'b0;
                ctr_q[i]   <= '0;
            end
            nb_q <= '0;
            nm_q <= '0;
        end else if (upd) begin
            nb_q <= nb_q + 32'd1;
            if (MispredictE) nm_q <= nm_q + 32'd1;
            if (hit_e) begin
                if (BranchE) ctr_q[idx_e] <= ctr_d;
                if (TakenE) tgt_q[idx_e] <= PCTargetE;
            end else if (TakenE) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
                tgt_q[idx_e]   <= PCTargetE;
                jmp_q[idx_e]   <= JumpE;
                ctr_q[idx_e]   <= CTR_WEAK;
            end
        end else if (inval) begin
            valid_q[idx_e] <= 1'b0;
        end
    end

    assign NumBranches    = nb_q;
    assign NumMispredicts = nm_q;
endmodule

// File: tb/tb_riscv_branch_predictor.sv
// tb_riscv_branch_predictor: scripted resolve/lookup sequence with a queue of expected outputs.
module tb_riscv_branch_predictor;
    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] nb;
        logic [31:0] nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = '0, PCE = '0, PCTargetE = '0, PredTargetE = '0;
    logic        BranchE = 1'b0, JumpE = 1'b0, TakenE = 1'b0, PredTakenE = 1'b0, StallE = 1'b0;
    logic        PredTakenF, MispredictE;
    logic [31:0] PredTargetF, RedirectPCE, NumBranches, NumMispredicts;
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    riscv_branch_predictor dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .PCE(PCE), .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE), .PCTargetE(PCTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .StallE(StallE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .NumBranches(NumBranches), .NumMispredicts(NumMispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] pcf, input logic [31:0] pce,
                        input logic br, input logic jp, input logic tk, input logic [31:0] tgte,
                        input logic pte, input logic [31:0] ptgte, input logic st,
                        input logic ept, input logic [31:0] eptgt, input logic emis,
                        input logic [31:0] eredir, input logic [31:0] enb, input logic [31:0] enm);
        exp_t e;
        @(negedge clk);
        reset = r; PCF = pcf; PCE = pce; BranchE = br; JumpE = jp; TakenE = tk;
        PCTargetE = tgte; PredTakenE = pte; PredTargetE = ptgte; StallE = st;
        exp_q.push_back('{ept, eptgt, emis, eredir, enb, enm});
        #2;
        e = exp_q.pop_front();
        chk("PredTakenF", {31'b0, PredTakenF}, {31'b0, e.pt});
        chk("PredTargetF", PredTargetF, e.ptgt);
        chk("MispredictE", {31'b0, MispredictE}, {31'b0, e.mis});
        chk("RedirectPCE", RedirectPCE, e.redir);
        chk("NumBranches", NumBranches, e.nb);
        chk("NumMispredicts", NumMispredicts, e.nm);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        //   rst pcf    pce    br jp tk tgte   pte ptgte  st | pt ptgt   mis redir  nb  nm
        step(1, 'h100, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h104, 0, 'h4,   0,  0);
        // allocate 0x100 -> 0x80, then train up and down
        step(0, 'h100, 'h100, 1, 0, 1, 'h80,  0, 'h104, 0,  0, 'h104, 1, 'h80,  0,  0);
        step(0, 'h100, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  1, 'h80,  0, 'h4,   1,  1);
        step(0, 'h100, 'h100, 1, 0, 1, 'h80,  1, 'h80,  0,  1, 'h80,  0, 'h80,  1,  1);
        step(0, 'h100, 'h100, 1, 0, 1, 'h80,  1, 'h80,  0,  1, 'h80,  0, 'h80,  2,  1);
        step(0, 'h100, 'h100, 1, 0, 1, 'h80,  1, 'h80,  0,  1, 'h80,  0, 'h80,  3,  1);
        step(0, 'h100, 'h100, 1, 0, 0, 'h80,  1, 'h80,  0,  1, 'h80,  1, 'h104, 4,  1);
        step(0, 'h100, 'h100, 1, 0, 0, 'h80,  1, 'h80,  0,  1, 'h80,  1, 'h104, 5,  2);
        step(0, 'h100, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h104, 0, 'h4,   6,  3);
        // stalled update has no effect
        step(0, 'h100, 'h100, 1, 0, 1, 'h500, 0, 'h0,   1,  0, 'h104, 0, 'h500, 6,  3);
        step(0, 'h100, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h104, 0, 'h4,   6,  3);
        // jal 0x200 -> 0x300, then not-taken branches at the same PC
        step(0, 'h200, 'h200, 0, 1, 1, 'h300, 0, 'h0,   0,  0, 'h204, 1, 'h300, 6,  3);
        step(0, 'h200, 'h200, 1, 0, 0, 'h0,   1, 'h300, 0,  1, 'h300, 1, 'h204, 7,  4);
        step(0, 'h200, 'h200, 1, 0, 0, 'h0,   1, 'h300, 0,  1, 'h300, 1, 'h204, 8,  5);
        step(0, 'h200, 'h200, 1, 0, 0, 'h0,   1, 'h300, 0,  1, 'h300, 1, 'h204, 9,  6);
        step(0, 'h200, 'h200, 1, 0, 0, 'h0,   1, 'h300, 0,  1, 'h300, 1, 'h204, 10, 7);
        step(0, 'h200, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  1, 'h300, 0, 'h4,   11, 8);
        // aliasing: 0x100 then 0x140 share index 0; same-cycle lookup sees old entry
        step(0, 'h100, 'h100, 1, 0, 1, 'h80,  0, 'h0,   0,  0, 'h104, 1, 'h80,  11, 8);
        step(0, 'h100, 'h140, 1, 0, 1, 'h40,  0, 'h0,   0,  1, 'h80,  1, 'h40,  12, 9);
        step(0, 'h100, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h104, 0, 'h4,   13, 10);
        step(0, 'h140, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  1, 'h40,  0, 'h4,   13, 10);
        // wrong target on a hit retargets the entry
        step(0, 'h140, 'h140, 1, 0, 1, 'h60,  1, 'h40,  0,  1, 'h40,  1, 'h60,  13, 10);
        step(0, 'h140, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  1, 'h60,  0, 'h4,   14, 11);
        // predicted-taken non-branch invalidates without counting
        step(0, 'h140, 'h140, 0, 0, 0, 'h0,   1, 'h60,  0,  1, 'h60,  1, 'h144, 14, 11);
        step(0, 'h140, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h144, 0, 'h4,   14, 11);
        // reset beats a coincident update
        step(0, 'h140, 'h140, 1, 0, 1, 'h40,  0, 'h0,   0,  0, 'h144, 1, 'h40,  14, 11);
        step(1, 'h140, 'h140, 1, 0, 1, 'h40,  0, 'h0,   0,  1, 'h40,  1, 'h40,  15, 12);
        step(0, 'h140, 'h0,   0, 0, 0, 'h0,   0, 'h0,   0,  0, 'h144, 0, 'h4,   0,  0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
